// File: rtl/dianti_sched_if.sv
// Request/status bundle between a button panel and the elevator scheduler.
// Latency: none, plain wires.
// Backpressure: none, request pulses are always accepted.
interface dianti_sched_if;
   logic [3:0] car_req;
   logic [2:0] hall_up;
   logic [2:0] hall_dn;
   logic [7:0] fl_num;
   logic [7:0] curr_st;
   logic [3:0] run_state;
   logic [3:0] door_state;
   logic [3:0] car_lamp;
   logic [2:0] up_lamp;
   logic [2:0] dn_lamp;

   // Panel side: drives button pulses, observes car status.
   modport master (
      output car_req, hall_up, hall_dn,
      input  fl_num, curr_st, run_state, door_state, car_lamp, up_lamp, dn_lamp
   );

   // Scheduler side.
   modport slave (
      input  car_req, hall_up, hall_dn,
      output fl_num, curr_st, run_state, door_state, car_lamp, up_lamp, dn_lamp
   );
endinterface

// File: rtl/dianti_sched.sv
// Four-floor elevator scheduler: latches buttons, picks direction, times travel and door.
// Latency: button pulse shows on its lamp one cycle later; all outputs registered.
// Backpressure: none, pulses always latch; repeats on a pending bit are absorbed.
module dianti_sched #(
   parameter int TICKS_PER_FLOOR = 570,
   parameter int DOOR_TICKS      = 380
) (
   input  logic         clk,
   input  logic         rst_n,   // active-high synchronous reset despite the name
   dianti_sched_if.slave bus
);

   typedef enum logic [7:0] {
      ST_IDLE = 8'd1,
      ST_UP   = 8'd2,
      ST_DOWN = 8'd3,
      ST_OPEN = 8'd4
   } state_t;

   typedef enum logic [1:0] {
      DIR_NONE = 2'd0,
      DIR_UP   = 2'd1,
      DIR_DN   = 2'd2
   } dir_t;

   localparam int TW = $clog2(TICKS_PER_FLOOR + 1);
   localparam int DW = $clog2(DOOR_TICKS + 1);
   localparam logic [TW-1:0] T_LAST = TW'(TICKS_PER_FLOOR - 1);
   localparam logic [DW-1:0] D_LAST = DW'(DOOR_TICKS - 1);

   localparam logic [3:0] RUN_UP    = 4'd10;
   localparam logic [3:0] RUN_DN    = 4'd11;
   localparam logic [3:0] RUN_STOP  = 4'd12;
   localparam logic [3:0] DOOR_OPEN = 4'd13;
   localparam logic [3:0] DOOR_SHUT = 4'd14;

   state_t        st;
   dir_t          dir;
   logic [2:0]    fl;        // 1..4
   logic [TW-1:0] tcnt;
   logic [DW-1:0] dcnt;
   logic [3:0]    car_q;
   logic [2:0]    up_q;
   logic [2:0]    dn_q;
   logic [3:0]    run_q;
   logic [3:0]    door_q;

   // Any bit set strictly above / below floor index i (0-based).
   function automatic logic above_of(input logic [3:0] v, input logic [1:0] i);
      return |(v & (4'b1110 << i));
   endfunction

   function automatic logic below_of(input logic [3:0] v, input logic [1:0] i);
      return |(v & ~(4'b1111 << i));
   endfunction

   // Pending requests including this cycle's pulses, re-indexed so bit i = floor i+1.
   logic [2:0] up_p, dn_p;
   logic [3:0] car_p, up_f, dn_f, any_f, hu_f, hd_f;
   logic [1:0] f, nf;
   logic [3:0] sel_f, sel_nf;
   logic       here_req, abv, blw, nabv, nblw, arrive, stop, pulse_here;

   assign car_p = car_q | bus.car_req;
   assign up_p  = up_q | bus.hall_up;
   assign dn_p  = dn_q | bus.hall_dn;
   assign up_f  = {1'b0, up_p};
   assign dn_f  = {dn_p, 1'b0};
   assign hu_f  = {1'b0, bus.hall_up};
   assign hd_f  = {bus.hall_dn, 1'b0};
   assign any_f = car_p | up_f | dn_f;

   assign f      = 2'(fl - 3'd1);
   // Next floor only matters while moving; UP never runs at floor 4 nor DOWN at floor 1.
   assign nf     = (st == ST_DOWN) ? (f - 2'd1) : (f + 2'd1);
   assign sel_f  = 4'b0001 << f;
   assign sel_nf = 4'b0001 << nf;

   assign here_req   = any_f[f];
   assign abv        = above_of(any_f, f);
   assign blw        = below_of(any_f, f);
   assign nabv       = above_of(any_f, nf);
   assign nblw       = below_of(any_f, nf);
   assign arrive     = ((st == ST_UP) || (st == ST_DOWN)) && (tcnt == T_LAST);
   assign stop       = arrive && ((st == ST_UP) ? (car_p[nf] | up_f[nf] | ~nabv)
                                                : (car_p[nf] | dn_f[nf] | ~nblw));
   assign pulse_here = |(sel_f & (bus.car_req | hu_f | hd_f));

   // Which pending bits are served this cycle (floor-indexed).
   logic [3:0] clr_car, clr_up, clr_dn;
   always_comb begin
      clr_car = 4'b0;
      clr_up  = 4'b0;
      clr_dn  = 4'b0;
      case (st)
         ST_IDLE: begin
            if (here_req) begin
               clr_car = sel_f;
               clr_up  = sel_f;
               clr_dn  = sel_f;
            end
         end
         ST_UP: begin
            if (stop) begin
               clr_car = sel_nf;
               clr_up  = sel_nf;
               // Reversal here: the down call is answered by this same stop.
               if (!nabv) clr_dn = sel_nf;
            end
         end
         ST_DOWN: begin
            if (stop) begin
               clr_car = sel_nf;
               clr_dn  = sel_nf;
               if (!nblw) clr_up = sel_nf;
            end
         end
         ST_OPEN: begin
            // A fresh press at the open floor is answered by the open door.
            clr_car = sel_f & bus.car_req;
            clr_up  = sel_f & hu_f;
            clr_dn  = sel_f & hd_f;
         end
         default: ;
      endcase
   end

   // Scheduler FSM, counters, floor and lamp registers.
   always_ff @(posedge clk) begin
      if (rst_n) begin
         st     <= ST_IDLE;
         dir    <= DIR_NONE;
         fl     <= 3'd1;
         tcnt   <= '0;
         dcnt   <= '0;
         car_q  <= '0;
         up_q   <= '0;
         dn_q   <= '0;
         run_q  <= RUN_STOP;
         door_q <= DOOR_SHUT;
      end else begin
         car_q <= car_p & ~clr_car;
         up_q  <= up_p & ~clr_up[2:0];
         dn_q  <= dn_p & ~clr_dn[3:1];
         case (st)
            ST_IDLE: begin
               if (here_req) begin
                  st     <= ST_OPEN;
                  dcnt   <= '0;
                  run_q  <= RUN_STOP;
                  door_q <= DOOR_OPEN;
               end else if ((dir == DIR_UP && abv) || (dir != DIR_DN && abv)) begin
                  st    <= ST_UP;
                  dir   <= DIR_UP;
                  tcnt  <= '0;
                  run_q <= RUN_UP;
               end else if (blw) begin
                  st    <= ST_DOWN;
                  dir   <= DIR_DN;
                  tcnt  <= '0;
                  run_q <= RUN_DN;
               end else if (abv) begin
                  // Last went down, nothing below: turn around.
                  st    <= ST_UP;
                  dir   <= DIR_UP;
                  tcnt  <= '0;
                  run_q <= RUN_UP;
               end else begin
                  dir <= DIR_NONE;
               end
            end
            ST_UP, ST_DOWN: begin
               if (arrive) begin
                  fl   <= (st == ST_UP) ? (fl + 3'd1) : (fl - 3'd1);
                  tcnt <= '0;
                  if (stop) begin
                     st     <= ST_OPEN;
                     dcnt   <= '0;
                     run_q  <= RUN_STOP;
                     door_q <= DOOR_OPEN;
                  end
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            ST_OPEN: begin
               if (pulse_here) begin
                  dcnt <= '0;
               end else if (dcnt == D_LAST) begin
                  st     <= ST_IDLE;
                  run_q  <= RUN_STOP;
                  door_q <= DOOR_SHUT;
               end else begin
                  dcnt <= dcnt + 1'b1;
               end
            end
            default: begin
               st     <= ST_IDLE;
               run_q  <= RUN_STOP;
               door_q <= DOOR_SHUT;
            end
         endcase
      end
   end

   assign bus.fl_num     = {5'd0, fl};
   assign bus.curr_st    = st;
   assign bus.run_state  = run_q;
   assign bus.door_state = door_q;
   assign bus.car_lamp   = car_q;
   assign bus.up_lamp    = up_q;
   assign bus.dn_lamp    = dn_q;

endmodule

// File: tb/tb_dianti_sched.sv
// Directed bench for dianti_sched with short travel/door times.
// Expectations are queued with the cycle they fall due; a negedge monitor compares.
// Covers reset, up/down travel, hall stops, door restart, mid-travel reset.
module tb_dianti_sched;

   logic clk = 1'b0;
   logic rst_n;
   dianti_sched_if bus ();

   dianti_sched #(.TICKS_PER_FLOOR(4), .DOOR_TICKS(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   localparam int F_FL = 0, F_ST = 1, F_RUN = 2, F_DOOR = 3, F_CAR = 4, F_UP = 5, F_DN = 6;

   typedef struct {
      int    at;
      int    fld;
      int    val;
      string nm;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   function automatic int actual(input int fld);
      case (fld)
         F_FL:    return int'(bus.fl_num);
         F_ST:    return int'(bus.curr_st);
         F_RUN:   return int'(bus.run_state);
         F_DOOR:  return int'(bus.door_state);
         F_CAR:   return int'(bus.car_lamp);
         F_UP:    return int'(bus.up_lamp);
         default: return int'(bus.dn_lamp);
      endcase
   endfunction

   function automatic string fname(input int fld);
      case (fld)
         F_FL:    return "fl_num";
         F_ST:    return "curr_st";
         F_RUN:   return "run_state";
         F_DOOR:  return "door_state";
         F_CAR:   return "car_lamp";
         F_UP:    return "up_lamp";
         default: return "dn_lamp";
      endcase
   endfunction

   function automatic void push_exp(input int d, input int fld, input int val, input string tag);
      exp_t e;
      e.at  = cyc + d;
      e.fld = fld;
      e.val = val;
      e.nm  = {tag, ".", fname(fld)};
      exp_q.push_back(e);
   endfunction

   function automatic void push_all(input int d, input string tag, input int fl, input int st,
                                    input int run, input int door, input int car,
                                    input int up, input int dn);
      push_exp(d, F_FL, fl, tag);
      push_exp(d, F_ST, st, tag);
      push_exp(d, F_RUN, run, tag);
      push_exp(d, F_DOOR, door, tag);
      push_exp(d, F_CAR, car, tag);
      push_exp(d, F_UP, up, tag);
      push_exp(d, F_DN, dn, tag);
   endfunction

   // Monitor: compare every expectation that falls due this cycle.
   initial begin
      forever begin
         @(negedge clk);
         for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].at <= cyc) begin
               int act;
               act = actual(exp_q[i].fld);
               checks++;
               if (exp_q[i].at != cyc || act != exp_q[i].val) begin
                  errors++;
                  $display("FAIL %s cycle %0d (due %0d): got %0d want %0d",
                           exp_q[i].nm, cyc, exp_q[i].at, act, exp_q[i].val);
               end
               exp_q.delete(i);
            end
         end
      end
   end

   task automatic go(input int t);
      while (cyc < t) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse(input logic [3:0] c, input logic [2:0] u, input logic [2:0] d);
      bus.car_req = c;
      bus.hall_up = u;
      bus.hall_dn = d;
      go(cyc + 1);
      bus.car_req = '0;
      bus.hall_up = '0;
      bus.hall_dn = '0;
   endtask

   int k;

   initial begin
      rst_n       = 1'b1;
      bus.car_req = '0;
      bus.hall_up = '0;
      bus.hall_dn = '0;
      go(2);
      rst_n = 1'b0;

      // Reset then idle.
      k = cyc;
      push_all(20, "idle", 1, 1, 12, 14, 0, 0, 0);
      go(k + 22);
      checks++;
      if (bus.fl_num != 8'd1) begin
         errors++;
         $display("FAIL idle direct fl_num: got %0d want 1", bus.fl_num);
      end
      checks++;
      if (bus.door_state != 4'd14) begin
         errors++;
         $display("FAIL idle direct door_state: got %0d want 14", bus.door_state);
      end

      // Car call to floor 4 from floor 1.
      k = cyc;
      push_exp(1, F_FL, 1, "a");
      push_exp(1, F_ST, 2, "a");
      push_exp(1, F_RUN, 10, "a");
      push_exp(1, F_CAR, 8, "a");
      push_exp(4, F_FL, 1, "a");
      push_exp(5, F_FL, 2, "a");
      push_exp(9, F_FL, 3, "a");
      push_exp(12, F_FL, 3, "a");
      push_all(13, "a_open", 4, 4, 12, 13, 0, 0, 0);
      push_exp(15, F_ST, 4, "a");
      push_all(16, "a_idle", 4, 1, 12, 14, 0, 0, 0);
      pulse(4'b1000, 3'b000, 3'b000);
      go(k + 20);

      // Travel down with two latched calls, reset while at floor 3.
      k = cyc;
      push_exp(1, F_FL, 4, "d");
      push_exp(1, F_ST, 3, "d");
      push_exp(1, F_RUN, 11, "d");
      push_exp(1, F_CAR, 1, "d");
      push_exp(1, F_UP, 2, "d");
      push_exp(5, F_FL, 3, "d");
      push_exp(5, F_ST, 3, "d");
      push_all(7, "d_rst", 1, 1, 12, 14, 0, 0, 0);
      push_exp(8, F_DN, 0, "d");
      push_exp(8, F_ST, 1, "d");
      pulse(4'b0001, 3'b010, 3'b000);
      go(k + 6);
      rst_n       = 1'b1;
      bus.hall_dn = 3'b111;
      go(k + 7);
      rst_n       = 1'b0;
      bus.hall_dn = 3'b000;
      go(k + 10);

      // Hall-up at 3 on the way to 4: stop at 3, then continue.
      k = cyc;
      push_exp(5, F_FL, 2, "b");
      push_exp(7, F_UP, 4, "b");
      push_all(9, "b_stop3", 3, 4, 12, 13, 8, 0, 0);
      push_exp(11, F_ST, 4, "b");
      push_exp(12, F_ST, 1, "b");
      push_exp(12, F_DOOR, 14, "b");
      push_exp(13, F_ST, 2, "b");
      push_exp(13, F_FL, 3, "b");
      push_exp(13, F_RUN, 10, "b");
      push_all(17, "b_stop4", 4, 4, 12, 13, 0, 0, 0);
      push_exp(20, F_ST, 1, "b");
      pulse(4'b1000, 3'b000, 3'b000);
      go(k + 6);
      pulse(4'b0000, 3'b100, 3'b000);
      go(k + 22);

      // Down to 1; press at the open floor restarts the door, other call latches.
      k = cyc;
      push_exp(1, F_ST, 3, "c");
      push_exp(9, F_FL, 2, "c");
      push_all(13, "c_open1", 1, 4, 12, 13, 0, 0, 0);
      push_all(15, "c_press", 1, 4, 12, 13, 0, 0, 2);
      push_exp(16, F_ST, 4, "c");
      push_exp(17, F_ST, 4, "c");
      push_exp(17, F_DOOR, 13, "c");
      push_all(18, "c_idle", 1, 1, 12, 14, 0, 0, 2);
      push_exp(19, F_ST, 2, "c");
      push_exp(23, F_FL, 2, "c");
      push_exp(23, F_ST, 2, "c");
      push_all(27, "c_stop3", 3, 4, 12, 13, 0, 0, 0);
      push_exp(30, F_ST, 1, "c");
      pulse(4'b0001, 3'b000, 3'b000);
      go(k + 14);
      pulse(4'b0000, 3'b001, 3'b010);
      go(k + 32);

      // Plain reset back to floor 1.
      push_all(1, "rst2", 1, 1, 12, 14, 0, 0, 0);
      rst_n = 1'b1;
      go(cyc + 1);
      rst_n = 1'b0;
      go(cyc + 2);
      checks++;
      if (bus.curr_st != 8'd1) begin
         errors++;
         $display("FAIL rst2 direct curr_st: got %0d want 1", bus.curr_st);
      end
      checks++;
      if ((bus.car_lamp | {1'b0, bus.up_lamp} | {1'b0, bus.dn_lamp}) != 4'd0) begin
         errors++;
         $display("FAIL rst2 direct lamps: car %0d up %0d dn %0d",
                  bus.car_lamp, bus.up_lamp, bus.dn_lamp);
      end

      // Hall-down at 3 on the way up: pass it, serve it on the way back.
      k = cyc;
      push_exp(7, F_CAR, 8, "e");
      push_exp(7, F_DN, 2, "e");
      push_all(9, "e_pass3", 3, 2, 10, 14, 8, 0, 2);
      push_all(13, "e_open4", 4, 4, 12, 13, 0, 0, 2);
      push_exp(16, F_ST, 1, "e");
      push_exp(17, F_ST, 3, "e");
      push_exp(17, F_RUN, 11, "e");
      push_all(21, "e_stop3", 3, 4, 12, 13, 0, 0, 0);
      push_exp(24, F_ST, 1, "e");
      push_exp(24, F_DOOR, 14, "e");
      pulse(4'b1000, 3'b000, 3'b000);
      go(k + 6);
      pulse(4'b1000, 3'b000, 3'b010);
      go(k + 26);
      checks++;
      if (bus.fl_num != 8'd3) begin
         errors++;
         $display("FAIL e direct fl_num: got %0d want 3", bus.fl_num);
      end
      checks++;
      if (bus.curr_st != 8'd1) begin
         errors++;
         $display("FAIL e direct curr_st: got %0d want 1", bus.curr_st);
      end
      checks++;
      if (bus.run_state != 4'd12) begin
         errors++;
         $display("FAIL e direct run_state: got %0d want 12", bus.run_state);
      end

      go(cyc + 2);
      while (exp_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL %s never compared: want %0d due %0d", exp_q[0].nm, exp_q[0].val, exp_q[0].at);
         void'(exp_q.pop_front());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dianti_sched.md
DIANTI_SCHED -- requirements
Module: dianti_sched

Interface
REQ-001 Parameter: TICKS_PER_FLOOR, default 570; clk cycles of travel per floor (3 s at 190 Hz).
REQ-002 Parameter: DOOR_TICKS, default 380; clk cycles the door stays open (2 s at 190 Hz).
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 rst_n  in  1  synchronous reset, active-high (1 = reset) despite the suffix.
REQ-005 car_req  in  4  in-car floor buttons, bit i = floor i+1; one-cycle pulses.
REQ-006 hall_up  in  3  hall UP buttons, bit i = floor i+1 (floors 1-3); one-cycle pulses.
REQ-007 hall_dn  in  3  hall DOWN buttons, bit i = floor i+2 (floors 2-4); one-cycle pulses.
REQ-008 fl_num  out  8  current floor, binary 1..4.
REQ-009 curr_st  out  8  state code: IDLE=1, UP=2, DOWN=3, OPEN=4.
REQ-010 run_state  out  4  10 = moving up, 11 = moving down, 12 = stopped.
REQ-011 door_state  out  4  13 = open, 14 = closed.
REQ-012 car_lamp / up_lamp / dn_lamp  out  4/3/3  pending-request registers, same bit mapping as inputs.

Function
REQ-013 All outputs shall be registered; an input pulse in cycle N shall set its lamp bit in cycle N+1.
REQ-014 Pending-request update per cycle: next = (lamp | pulse) & ~clear; clear shall be computed from (lamp | pulse) in the same cycle.
REQ-015 "above" / "below" shall mean any pending bit (car or hall) at a floor strictly above / below fl_num.
REQ-016 A direction register dir (NONE/UP/DN) shall hold the last travel direction.
REQ-017 IDLE, door closed:
- any request at fl_num -> OPEN; clear all bits at fl_num.
- else dir=UP and above -> UP.
- else dir=DN and below -> DOWN.
- else above -> UP; else below -> DOWN.
- else stay in IDLE with dir=NONE.
REQ-018 UP/DOWN: the travel counter shall run 0..TICKS_PER_FLOOR-1; on the terminal count fl_num shall increment/decrement by 1 and the counter shall reset.
REQ-019 Arrival at floor f while moving UP: stop (-> OPEN) if car_req[f] or hall_up[f] is pending, or no request above f.
- On stop, clear car bit and up bit at f.
- Clear the down bit at f as well if nothing is above f.
- Otherwise continue UP with a fresh count. DOWN is symmetric.
REQ-020 fl_num shall never leave 1..4; UP at floor 4 and DOWN at floor 1 shall be impossible by construction.
REQ-021 OPEN: door_state=13, run_state=12. After DOOR_TICKS cycles go to IDLE with door_state=14.
REQ-022 A request for fl_num arriving during OPEN shall be cleared immediately (lamp never rises) and the door counter shall restart.
REQ-023 Requests at other floors during OPEN shall latch and shall be served after the return to IDLE.
REQ-024 run_state shall be 10 in UP, 11 in DOWN, 12 otherwise; door_state shall be 14 in all states except OPEN.
REQ-025 A repeated pulse on an already-pending bit shall have no effect; simultaneous pulses on several inputs shall all latch.

Reset
REQ-026 rst_n=1 at a clock edge shall force:
- fl_num=1, curr_st=1, dir=NONE, run_state=12, door_state=14
- all lamps 0, both counters 0
REQ-027 Reset shall take effect at the same edge even mid-travel or mid-door, with no partial floor retained; input pulses in a reset cycle shall be discarded.

Verification (TICKS_PER_FLOOR=4, DOOR_TICKS=3)
REQ-028 Reset then idle 20 cycles -> fl_num=1, curr_st=1, run_state=12, door_state=14, lamps 0.
REQ-029 car_req=4'b1000 pulse at floor 1 -> car_lamp[3]=1 next cycle, run_state=10.
- fl_num steps 2,3,4, one step per 4 cycles.
- At floor 4: OPEN, door_state=13, car_lamp=0; IDLE 3 cycles later.
REQ-030 Car moving up from 1 with car_req floor 4 pending; hall_up floor 3 pulsed before reaching 3 -> stop at 3, up_lamp[2] cleared, then continue to 4.
REQ-031 Same as REQ-030 but hall_dn floor 3 pulsed -> no stop at 3 on the way up; after floor 4 the car returns down to 3 and clears dn_lamp[1].
REQ-032 hall_up floor 1 pulsed while OPEN at floor 1 -> up_lamp[0] stays 0 and the door stays open 3 cycles from that pulse.
REQ-033 rst_n asserted while fl_num=3 moving down with lamps set -> next cycle fl_num=1, curr_st=1, all lamps 0.
